mps_data_capture: RTL and testbench
===================================

MPS_DATA_CAPTURE -- requirements
Module: mps_data_capture

Interface
REQ-001 SHALL have parameter CH_NUM, default 12: number of ADC channels captured (1..32).
REQ-002 SHALL have parameter DATA_W, default 32: sample and stream word width (>=32).
REQ-003 SHALL have parameter AVG_LOG2, default 4: log2 of samples per averaging block (1..8).
REQ-004 SHALL have port i_clk, input, 1: sole clock.
REQ-005 SHALL have port i_rst, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port i_adc_tdata, input, CH_NUM*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W], signed.
REQ-007 SHALL have port i_adc_tvalid, input, CH_NUM: per-channel sample strobe.
REQ-008 SHALL have port i_snap_req, input, 1: snapshot/frame request pulse.
REQ-009 SHALL have port o_ch_data, output, CH_NUM*DATA_W: latest latched sample per channel.
REQ-010 SHALL have port o_ch_avg, output, CH_NUM*DATA_W: latest block average per channel.
REQ-011 SHALL have port m_axis_tdata, output, DATA_W: frame stream data.
REQ-012 SHALL have ports m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1: AXIS frame handshake.
REQ-013 SHALL have port o_busy, output, 1: high in SNAP or SEND state.
REQ-014 SHALL have port o_seq_cnt, output, 16: frames completed, wraps 0xFFFF->0.
REQ-015 SHALL have port o_drop_cnt, output, 16: requests rejected while busy, saturates at 0xFFFF.

Function
REQ-016 SHALL latch channel k into o_ch_data on every cycle i_adc_tvalid[k]=1, holding otherwise; 1-cycle latency.
REQ-017 SHALL run FSM IDLE -> SNAP (on i_snap_req) -> SEND -> IDLE (after tlast handshake).
REQ-018 SHALL in SNAP copy o_ch_data (and o_ch_avg when averaging built) into a shadow buffer in one cycle; samples arriving later never alter the frame in flight.
REQ-019 SHALL emit in SEND word 0 = header {zero-pad, 16'hA55A, o_seq_cnt}, then shadow channels 0..CH_NUM-1 ascending.
REQ-020 SHALL advance word index only when m_axis_tvalid & m_axis_tready; tvalid, once high, stays high with stable tdata until accepted.
REQ-021 SHALL assert m_axis_tlast with the final word only; on its acceptance increment o_seq_cnt and return to IDLE.
REQ-022 SHALL ignore i_snap_req in SNAP/SEND and increment o_drop_cnt (saturating); a request in the same cycle SEND->IDLE is also dropped.
REQ-023 SHALL hold o_busy and tvalid low in IDLE; first tvalid occurs 2 cycles after i_snap_req sampled.

Reset
REQ-024 SHALL on i_rst low asynchronously force FSM IDLE and clear o_ch_data, o_ch_avg, accumulators, block counters, shadow buffer, word index, o_seq_cnt, o_drop_cnt, m_axis_tvalid, m_axis_tlast, m_axis_tdata, o_busy to 0.
REQ-025 SHALL abandon any frame mid-transfer on reset with no tlast issued; after release first frame carries seq 0.

Configuration
REQ-026 SHALL, with MPS_DATA_AVG_EN defined, per channel sum 2^AVG_LOG2 valid samples into a signed DATA_W+AVG_LOG2 accumulator, then load o_ch_avg = sum arithmetic-shifted right AVG_LOG2 and restart the sum, the block's last sample included.
REQ-027 SHALL, with MPS_DATA_AVG_EN defined, make frames 1+2*CH_NUM words: header, CH_NUM latest samples, then CH_NUM averages.
REQ-028 SHALL, without MPS_DATA_AVG_EN, omit accumulators, tie o_ch_avg to 0, and make frames 1+CH_NUM words.

Verification
REQ-029 SHALL cover: CH_NUM=3, channels 0x11,0x22,0x33 latched, i_snap_req, tready=1 -> words 0x0000A55A... wait-free: 0xA55A0000,0x11,0x22,0x33, tlast on 4th, o_seq_cnt=1.
REQ-030 SHALL cover: tready toggled 1/0 every cycle during frame -> identical word sequence, tdata stable while stalled, 4 handshakes total.
REQ-031 SHALL cover: ch0 updated to 0x99 one cycle after i_snap_req -> frame carries 0x11, o_ch_data shows 0x99.
REQ-032 SHALL cover: three i_snap_req pulses during one SEND -> o_drop_cnt=3, only one frame emitted.
REQ-033 SHALL cover (MPS_DATA_AVG_EN, AVG_LOG2=2): ch0 samples -4,-4,-4,-8 -> o_ch_avg ch0 = -5 after 4th sample.
REQ-034 SHALL cover: i_rst low after word 1 accepted -> tvalid 0 immediately, counters 0, next frame header seq 0.

Source files
------------

// File: rtl/mps_data_capture.sv
// Multi-channel ADC sample capture with snapshot framing onto an AXI-Stream master.
// Optional per-channel block averaging is built when MPS_DATA_AVG_EN is defined.
module mps_data_capture #(
    parameter int unsigned CH_NUM   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CH_NUM*DATA_W-1:0] i_adc_tdata,
    input  logic [CH_NUM-1:0]        i_adc_tvalid,
    input  logic                     i_snap_req,
    output logic [CH_NUM*DATA_W-1:0] o_ch_data,
    output logic [CH_NUM*DATA_W-1:0] o_ch_avg,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     o_busy,
    output logic [15:0]              o_seq_cnt,
    output logic [15:0]              o_drop_cnt
);

`ifdef MPS_DATA_AVG_EN
    localparam int unsigned FRAME_WORDS = 1 + 2 * CH_NUM;
    localparam int unsigned ACC_W       = DATA_W + AVG_LOG2;
`else
    localparam int unsigned FRAME_WORDS = 1 + CH_NUM;
`endif
    localparam int unsigned IDX_W    = $clog2(FRAME_WORDS);
    localparam int unsigned LAST_IDX = FRAME_WORDS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   ch_data_q [CH_NUM];
    logic [DATA_W-1:0]   ch_avg_q  [CH_NUM];
    logic [DATA_W-1:0]   shadow_q  [FRAME_WORDS-1];
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    nxt_idx_c;
    logic [DATA_W-1:0]   word_c;
    logic [15:0]         seq_q;
    logic [15:0]         drop_q;

    // Latest sample per channel
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned k = 0; k < CH_NUM; k++) ch_data_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < CH_NUM; k++)
                if (i_adc_tvalid[k]) ch_data_q[k] <= i_adc_tdata[k*DATA_W +: DATA_W];
        end
    end

`ifdef MPS_DATA_AVG_EN
    logic signed [ACC_W-1:0]    acc_q [CH_NUM];
    logic        [AVG_LOG2-1:0] cnt_q [CH_NUM];
    logic signed [ACC_W-1:0]    sum_c [CH_NUM];

    always_comb begin
        for (int unsigned k = 0; k < CH_NUM; k++)
            sum_c[k] = acc_q[k] + ACC_W'(signed'(i_adc_tdata[k*DATA_W +: DATA_W]));
    end

    // Block sum; the closing sample is folded in before the divide-by-shift
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned k = 0; k < CH_NUM; k++) begin
                acc_q[k]    <= '0;
                cnt_q[k]    <= '0;
                ch_avg_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < CH_NUM; k++) begin
                if (i_adc_tvalid[k]) begin
                    if (cnt_q[k] == '1) begin
                        ch_avg_q[k] <= DATA_W'(sum_c[k] >>> AVG_LOG2);
                        acc_q[k]    <= '0;
                        cnt_q[k]    <= '0;
                    end else begin
                        acc_q[k] <= sum_c[k];
                        cnt_q[k] <= cnt_q[k] + AVG_LOG2'(1);
                    end
                end
            end
        end
    end
`else
    always_comb begin
        for (int unsigned k = 0; k < CH_NUM; k++) ch_avg_q[k] = '0;
    end
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_out
        assign o_ch_data[g*DATA_W +: DATA_W] = ch_data_q[g];
        assign o_ch_avg[g*DATA_W +: DATA_W]  = ch_avg_q[g];
    end

    // Payload word that follows the one currently presented
    always_comb begin
        nxt_idx_c = idx_q + IDX_W'(1);
        word_c    = '0;
        for (int unsigned n = 1; n < FRAME_WORDS; n++)
            if (nxt_idx_c == IDX_W'(n)) word_c = shadow_q[n-1];
    end

    // Frame sequencer
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            seq_q         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_busy        <= 1'b0;
            for (int unsigned n = 0; n < FRAME_WORDS - 1; n++) shadow_q[n] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_snap_req) begin
                        state_q <= ST_SNAP;
                        o_busy  <= 1'b1;
                    end
                end
                ST_SNAP: begin
                    for (int unsigned k = 0; k < CH_NUM; k++) begin
                        shadow_q[k] <= ch_data_q[k];
`ifdef MPS_DATA_AVG_EN
                        shadow_q[CH_NUM+k] <= ch_avg_q[k];
`endif
                    end
                    idx_q         <= '0;
                    m_axis_tdata  <= DATA_W'({16'hA55A, seq_q});
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= 1'b0;
                    state_q       <= ST_SEND;
                end
                ST_SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            o_busy        <= 1'b0;
                            seq_q         <= seq_q + 16'd1;
                            state_q       <= ST_IDLE;
                        end else begin
                            idx_q        <= nxt_idx_c;
                            m_axis_tdata <= word_c;
                            m_axis_tlast <= (nxt_idx_c == IDX_W'(LAST_IDX));
                        end
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

    // Requests arriving outside IDLE are counted, never queued
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            drop_q <= '0;
        end else if (i_snap_req && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign o_seq_cnt  = seq_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_mps_data_capture.sv
// Directed + randomized bench for mps_data_capture against a cycle-level frame model.
module tb_mps_data_capture;
    localparam int CH = 3;
    localparam int DW = 32;
    localparam int AL = 2;
`ifdef MPS_DATA_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    localparam int FW = AVG_EN ? 1 + 2 * CH : 1 + CH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CH*DW-1:0]  adc_data = '0;
    logic [CH-1:0]     adc_valid = '0;
    logic              snap_req = 1'b0;
    logic [CH*DW-1:0]  ch_data, ch_avg;
    logic [DW-1:0]     tdata;
    logic              tvalid, tready = 1'b0, tlast;
    logic              busy;
    logic [15:0]       seq_cnt, drop_cnt;

    mps_data_capture #(.CH_NUM(CH), .DATA_W(DW), .AVG_LOG2(AL)) dut (
        .i_clk(clk), .i_rst(rst), .i_adc_tdata(adc_data), .i_adc_tvalid(adc_valid),
        .i_snap_req(snap_req), .o_ch_data(ch_data), .o_ch_avg(ch_avg),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .o_busy(busy), .o_seq_cnt(seq_cnt), .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] m_ch [CH];
    logic [DW-1:0] m_avg [CH];
    longint        m_sum [CH];
    int            m_n [CH];
    bit            m_busy, snap_cd;
    logic [15:0]   m_seq, m_drop;
    logic [DW-1:0] exp_q [$];
    int            cyc, req_cyc, hs_cnt;
    bit            prev_valid, prev_ready;
    logic [DW-1:0] prev_data;
    int            vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_ch[k] = '0; m_avg[k] = '0; m_sum[k] = 0; m_n[k] = 0;
        end
        m_busy = 0; snap_cd = 0; m_seq = '0; m_drop = '0;
        exp_q.delete();
        prev_valid = 0; prev_ready = 0; prev_data = '0;
    endtask

    // Check current outputs, account for what the coming edge samples, then advance
    task automatic cycle();
        bit last_acc;
        longint s;
        last_acc = 0;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("seq_cnt", 64'(seq_cnt), 64'(m_seq));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        for (int k = 0; k < CH; k++) begin
            chk("ch_data", 64'(ch_data[k*DW +: DW]), 64'(m_ch[k]));
            chk("ch_avg", 64'(ch_avg[k*DW +: DW]), 64'(m_avg[k]));
        end
        if (prev_valid && !prev_ready) begin
            chk("stall_tvalid", 64'(tvalid), 64'd1);
            chk("stall_tdata", 64'(tdata), 64'(prev_data));
        end
        if (!prev_valid && tvalid) chk("first_tvalid_latency", 64'(cyc - req_cyc), 64'd2);
        if (!tvalid) chk("idle_tlast", 64'(tlast), 64'd0);
        if (snap_cd) begin
            exp_q.push_back(DW'({16'hA55A, m_seq}));
            for (int k = 0; k < CH; k++) exp_q.push_back(m_ch[k]);
            if (AVG_EN) for (int k = 0; k < CH; k++) exp_q.push_back(m_avg[k]);
            snap_cd = 0;
        end
        if (tvalid && tready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(tdata), 64'hDEAD_0000_0000_0000);
            end else begin
                chk("word", 64'(tdata), 64'(exp_q[0]));
                chk("tlast", 64'(tlast), 64'(exp_q.size() == 1));
                last_acc = (exp_q.size() == 1);
                void'(exp_q.pop_front());
            end
        end
        if (snap_req) begin
            if (m_busy) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                m_busy = 1; snap_cd = 1; req_cyc = cyc;
            end
        end
        if (last_acc) begin
            m_seq++;
            m_busy = 0;
        end
        for (int k = 0; k < CH; k++) begin
            if (adc_valid[k]) begin
                m_ch[k] = adc_data[k*DW +: DW];
                if (AVG_EN) begin
                    s = longint'($signed(adc_data[k*DW +: DW]));
                    m_sum[k] += s;
                    m_n[k]++;
                    if (m_n[k] == (1 << AL)) begin
                        m_avg[k] = DW'(m_sum[k] >>> AL);
                        m_sum[k] = 0;
                        m_n[k] = 0;
                    end
                end
            end
        end
        prev_valid = tvalid; prev_ready = tready; prev_data = tdata;
        @(posedge clk); #1;
        cyc++;
    endtask

    // mode 0: hold tready, 1: toggle every cycle, 2: random
    task automatic wait_idle(input int mode, input int budget);
        int n;
        n = 0;
        while ((m_busy || exp_q.size() != 0) && n < budget) begin
            if (mode == 1) tready = cyc[0];
            else if (mode == 2) tready = 1'($urandom);
            cycle();
            n++;
        end
        chk("frame_done_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int d0, n;
        cyc = 0; req_cyc = -100; hs_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_ch_data", 64'(ch_data[63:0]), 64'd0);
        rst = 1'b1;

        // Basic frame with three latched channels
        adc_data = {32'h33, 32'h22, 32'h11}; adc_valid = '1;
        cycle();
        adc_valid = '0;
        cycle();
        snap_req = 1'b1; tready = 1'b1;
        cycle();
        snap_req = 1'b0;
        wait_idle(0, 40);
        chk("seq_after_frame1", 64'(seq_cnt), 64'd1);

        // Back-pressure every other cycle
        hs_cnt = 0;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        wait_idle(1, 60);
        chk("toggle_handshakes", 64'(hs_cnt), 64'(FW));

        // Sample landing during SNAP must not reach the frame
        snap_req = 1'b1; tready = 1'b1;
        cycle();
        snap_req = 1'b0;
        adc_data[31:0] = 32'h99; adc_valid = 3'b001;
        cycle();
        adc_valid = '0;
        wait_idle(0, 40);
        chk("ch0_after_snap", 64'(ch_data[31:0]), 64'h99);

        // Requests while busy are dropped
        tready = 1'b0; hs_cnt = 0;
        d0 = int'(drop_cnt);
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        cycle(); cycle();
        for (int i = 0; i < 3; i++) begin
            snap_req = 1'b1; cycle();
            snap_req = 1'b0; cycle();
        end
        tready = 1'b1;
        wait_idle(0, 40);
        repeat (4) cycle();
        chk("drop_delta", 64'(int'(drop_cnt) - d0), 64'd3);
        chk("single_frame_handshakes", 64'(hs_cnt), 64'(FW));

        // Block averaging of negative samples on channel 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            adc_data[31:0] = (i == 3) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
            adc_valid = 3'b001;
            cycle();
        end
        adc_valid = '0;
        cycle();
        chk("avg_ch0", 64'(ch_avg[31:0]), AVG_EN ? 64'hFFFF_FFFB : 64'd0);
        snap_req = 1'b1; tready = 1'b1;
        cycle();
        snap_req = 1'b0;
        wait_idle(0, 40);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            adc_data = {$urandom, $urandom, $urandom};
            adc_valid = CH'($urandom);
            snap_req = ($urandom_range(0, 11) == 0);
            tready = 1'($urandom);
            cycle();
        end
        snap_req = 1'b0; adc_valid = '0;
        wait_idle(2, 200);

        // Reset in the middle of a frame
        hs_cnt = 0; tready = 1'b1;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        n = 0;
        while (hs_cnt < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("midframe_handshakes", 64'(hs_cnt), 64'd2);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_tvalid", 64'(tvalid), 64'd0);
        chk("rst_mid_tlast", 64'(tlast), 64'd0);
        chk("rst_mid_seq", 64'(seq_cnt), 64'd0);
        chk("rst_mid_drop", 64'(drop_cnt), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        wait_idle(0, 40);
        chk("seq_after_reset_frame", 64'(seq_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1);
    end

endmodule
